// File: rtl/rupt_sequencer.sv
// Interrupt sequencer: latch requests, wait for a safe boundary, drain E/W, inject the vector, then block until RESUME.
// Latency: 2+DRAIN_CYCLES cycles from request to redirect; hold/flush are ORed into the core's stall_D/flush_E.
module rupt_sequencer #(
    parameter int          N_RUPT        = 10,
    parameter logic [14:0] VECTOR_BASE   = 15'o4004,
    parameter int          VECTOR_STRIDE = 4,
    parameter int          DRAIN_CYCLES  = 2
) (
    input  logic              clock,
    input  logic              rst_l,
    input  logic [N_RUPT-1:0] rupt_req,
    input  logic              inhint_W,
    input  logic              relint_W,
    input  logic              resume_W,
    input  logic              prefix_D,
    input  logic              ovf_A,
    input  logic              stall_D,
    input  logic              branch_E,
    input  logic [14:0]       branch_target_E,
    input  logic [14:0]       pc_D,
    output logic              rupt_hold,
    output logic              rupt_flush,
    output logic              rupt_redirect,
    output logic [14:0]       rupt_vector,
    output logic              zrupt_we,
    output logic [14:0]       zrupt_data,
    output logic [N_RUPT-1:0] rupt_ack,
    output logic [N_RUPT-1:0] pending,
    output logic              rupt_en,
    output logic              in_isr
);
    localparam int WW = (N_RUPT > 1) ? $clog2(N_RUPT) : 1;

    typedef enum logic [1:0] {IDLE, HOLD, INJECT, ISR} state_t;

    state_t            state_q;
    logic [2:0]        cnt_q;
    logic [WW-1:0]     win_q;
    logic [WW-1:0]     winner;
    logic [N_RUPT-1:0] pending_q, pending_d;
    logic [N_RUPT-1:0] ack_q;
    logic [14:0]       saved_pc_q, vector_q;
    logic              hold_q, flush_q, redir_q, we_q, isr_q, en_q;
    logic              eligible;

    function automatic logic [14:0] vec_of(input logic [WW-1:0] w);
        vec_of = 15'(int'(VECTOR_BASE) + VECTOR_STRIDE * int'(w));
    endfunction

    // Lowest index wins: scan from the top so the last hit is the highest priority.
    always_comb begin
        winner = '0;
        for (int i = N_RUPT - 1; i >= 0; i--)
            if (pending_q[i]) winner = WW'(i);
    end

    assign eligible  = (|pending_q) & en_q & ~isr_q & ~ovf_A & ~prefix_D & ~stall_D & ~branch_E;
    // A request in the same cycle as its ack keeps the bit set.
    assign pending_d = (pending_q & ~ack_q) | rupt_req;

    always_ff @(posedge clock or negedge rst_l) begin
        if (!rst_l) begin
            pending_q <= '0;
            en_q      <= 1'b0;
        end else begin
            pending_q <= pending_d;
            if (inhint_W)      en_q <= 1'b0;
            else if (relint_W) en_q <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge rst_l) begin
        if (!rst_l) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            win_q      <= '0;
            saved_pc_q <= '0;
            vector_q   <= '0;
            hold_q     <= 1'b0;
            flush_q    <= 1'b0;
            redir_q    <= 1'b0;
            we_q       <= 1'b0;
            ack_q      <= '0;
            isr_q      <= 1'b0;
        end else begin
            flush_q <= 1'b0;
            redir_q <= 1'b0;
            we_q    <= 1'b0;
            ack_q   <= '0;
            case (state_q)
                IDLE: begin
                    if (eligible) begin
                        state_q    <= HOLD;
                        win_q      <= winner;
                        saved_pc_q <= pc_D;
                        vector_q   <= vec_of(winner);
                        cnt_q      <= 3'(DRAIN_CYCLES);
                        hold_q     <= 1'b1;
                    end
                end
                HOLD: begin
                    cnt_q <= cnt_q - 3'd1;
                    // An older taken branch retiring means execution resumes at its target.
                    if (branch_E) saved_pc_q <= branch_target_E;
                    if (inhint_W) begin
                        state_q <= IDLE;
                        hold_q  <= 1'b0;
                    end else if (cnt_q == 3'd1) begin
                        state_q <= INJECT;
                        flush_q <= 1'b1;
                        redir_q <= 1'b1;
                        we_q    <= 1'b1;
                        ack_q   <= N_RUPT'(1) << win_q;
                        isr_q   <= 1'b1;
                    end
                end
                INJECT: begin
                    state_q <= ISR;
                    hold_q  <= 1'b0;
                end
                ISR: begin
                    if (resume_W) begin
                        state_q <= IDLE;
                        isr_q   <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rupt_hold     = hold_q;
    assign rupt_flush    = flush_q;
    assign rupt_redirect = redir_q;
    assign rupt_vector   = vector_q;
    assign zrupt_we      = we_q;
    assign zrupt_data    = saved_pc_q;
    assign rupt_ack      = ack_q;
    assign pending       = pending_q;
    assign rupt_en       = en_q;
    assign in_isr        = isr_q;
endmodule
